pipe_stall_ctrl: RTL and testbench

- Central pipeline controller for the 5-stage core. It generates the 6-bit stall vector consumed by pc_reg, if_id, id_ex, ex_mem and mem_wb.
- Stall vector bit assignment: bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB.
- Sequences multi-cycle EX operations (div/madd) with an internal countdown.
- Issues a registered one-cycle flush with a redirect PC on exception.

---
 rtl/pipe_stall_ctrl.sv | 158 +++++++++++++++
 tb/tb_pipe_stall_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush controller: priority stall vector, multi-cycle EX sequencing,
// registered exception flush. Optional stall watchdog enabled by PIPE_CTRL_WDT_EN.
module pipe_stall_ctrl #(
  parameter int MC_W      = 6,
  parameter int WDT_LIMIT = 1023,
  parameter int WDT_W     = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stallreq_if,
  input  logic            stallreq_id,
  input  logic            stallreq_ex,
  input  logic            stallreq_mem,
  input  logic            ex_mc_start,
  input  logic [MC_W-1:0] ex_mc_cycles,
  input  logic            excp_req,
  input  logic [31:0]     excp_pc,
  output logic [5:0]      stall,
  output logic            flush,
  output logic [31:0]     new_pc,
  output logic            ex_mc_done,
  output logic            busy,
  output logic            wdt_timeout
);

  // state    | meaning
  // ST_IDLE  | normal issue, accepts exceptions and multi-cycle starts
  // ST_MULTI | multi-cycle EX op counting down, EX held
  // ST_FLUSH | one-cycle flush, redirect to pc_q
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MULTI = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [MC_W-1:0] cnt_q, cnt_d;
  logic [31:0]     pc_q, pc_d;
  logic            done_q, done_d;

  logic            mc_go;
  logic            ex_eff;
  logic [5:0]      stall_raw;
  logic            flush_int;

  assign mc_go = ex_mc_start & (ex_mc_cycles != '0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pc_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (excp_req) begin
          pc_d    = excp_pc;
          state_d = ST_FLUSH;
        end else if (mc_go) begin
          cnt_d   = ex_mc_cycles;
          state_d = ST_MULTI;
        end
      end
      ST_MULTI: begin
        if (excp_req) begin
          pc_d    = excp_pc;
          cnt_d   = '0;
          state_d = ST_FLUSH;
        end else begin
          cnt_d = cnt_q - MC_W'(1);
          if (cnt_q == MC_W'(1)) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      ST_FLUSH: begin
        // A new exception while flushing re-arms the flush with the newer handler.
        if (excp_req) begin
          pc_d    = excp_pc;
          state_d = ST_FLUSH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign ex_eff = stallreq_ex | (state_q == ST_MULTI) | ((state_q == ST_IDLE) & mc_go);

  // WB is never stalled so mem_wb bubbles whenever MEM holds.
  always_comb begin
    stall_raw = 6'b000000;
    if (state_q != ST_FLUSH) begin
      if (stallreq_mem)     stall_raw = 6'b011111;
      else if (ex_eff)      stall_raw = 6'b001111;
      else if (stallreq_id) stall_raw = 6'b000111;
      else if (stallreq_if) stall_raw = 6'b000011;
    end
  end

  assign flush_int  = rst & (state_q == ST_FLUSH);
  assign stall      = rst ? stall_raw : 6'b000000;
  assign flush      = flush_int;
  assign new_pc     = flush_int ? pc_q : 32'h0000_0000;
  assign ex_mc_done = rst & done_q;
  assign busy       = rst & (state_q == ST_MULTI);

`ifdef PIPE_CTRL_WDT_EN
  localparam logic [WDT_W-1:0] WDT_LIM = WDT_W'(WDT_LIMIT);

  logic [WDT_W-1:0] wdt_cnt_q, wdt_cnt_d;
  logic             wdt_to_q, wdt_to_d;

  always_comb begin
    wdt_cnt_d = wdt_cnt_q;
    wdt_to_d  = wdt_to_q;
    if (stall_raw == 6'b000000) begin
      wdt_cnt_d = '0;
    end else if (wdt_cnt_q != WDT_LIM) begin
      wdt_cnt_d = wdt_cnt_q + WDT_W'(1);
    end
    if (wdt_cnt_d == WDT_LIM) wdt_to_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wdt_cnt_q <= '0;
      wdt_to_q  <= 1'b0;
    end else begin
      wdt_cnt_q <= wdt_cnt_d;
      wdt_to_q  <= wdt_to_d;
    end
  end

  assign wdt_timeout = rst & wdt_to_q;
`else
  assign wdt_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scoreboarded bench for pipe_stall_ctrl; watchdog expectations follow PIPE_CTRL_WDT_EN.
module tb_pipe_stall_ctrl;

  typedef struct packed {
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] pc;
    logic        done;
    logic        busy;
    logic        wdt;
  } exp_t;

`ifdef PIPE_CTRL_WDT_EN
  localparam logic WD = 1'b1;
`else
  localparam logic WD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        s_if, s_id, s_ex, s_mem;
  logic        mc_start;
  logic [5:0]  mc_cyc;
  logic        excp;
  logic [31:0] epc;

  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        ex_mc_done;
  logic        busy;
  logic        wdt_timeout;

  int checks = 0;
  int errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  pipe_stall_ctrl #(.MC_W(6), .WDT_LIMIT(8), .WDT_W(16)) dut (
    .clk(clk), .rst(rst),
    .stallreq_if(s_if), .stallreq_id(s_id), .stallreq_ex(s_ex), .stallreq_mem(s_mem),
    .ex_mc_start(mc_start), .ex_mc_cycles(mc_cyc),
    .excp_req(excp), .excp_pc(epc),
    .stall(stall), .flush(flush), .new_pc(new_pc),
    .ex_mc_done(ex_mc_done), .busy(busy), .wdt_timeout(wdt_timeout)
  );

  function automatic exp_t mk(input logic [5:0] st, input logic fl, input logic [31:0] pc,
                              input logic dn, input logic bz, input logic wd);
    exp_t e;
    e.stall = st; e.flush = fl; e.pc = pc; e.done = dn; e.busy = bz; e.wdt = wd;
    return e;
  endfunction

  function automatic logic [5:0] prio(input logic m, input logic e, input logic i, input logic f);
    if (m) return 6'b011111;
    if (e) return 6'b001111;
    if (i) return 6'b000111;
    if (f) return 6'b000011;
    return 6'b000000;
  endfunction

  task automatic clr_in();
    s_if = 0; s_id = 0; s_ex = 0; s_mem = 0;
    mc_start = 0; mc_cyc = '0; excp = 0; epc = '0;
  endtask

  // Called just after a negedge with inputs already applied; samples before the next posedge.
  task automatic step(input string tag, input exp_t e);
    exp_t x;
    sb.push_back(e);
    #2;
    x = sb.pop_front();
    checks++;
    if (stall !== x.stall) begin
      errors++; $display("FAIL %s stall: got %b want %b", tag, stall, x.stall);
    end
    if (flush !== x.flush) begin
      errors++; $display("FAIL %s flush: got %b want %b", tag, flush, x.flush);
    end
    if (new_pc !== x.pc) begin
      errors++; $display("FAIL %s new_pc: got %h want %h", tag, new_pc, x.pc);
    end
    if (ex_mc_done !== x.done) begin
      errors++; $display("FAIL %s ex_mc_done: got %b want %b", tag, ex_mc_done, x.done);
    end
    if (busy !== x.busy) begin
      errors++; $display("FAIL %s busy: got %b want %b", tag, busy, x.busy);
    end
    if (wdt_timeout !== x.wdt) begin
      errors++; $display("FAIL %s wdt_timeout: got %b want %b", tag, wdt_timeout, x.wdt);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    s_if = 1; s_id = 1; s_ex = 1; s_mem = 1;
    mc_start = 1; mc_cyc = 6'd3; excp = 1; epc = 32'hDEAD_BEEF;
    rst = 0;
    repeat (3) step("reset_hold", mk(6'b0, 0, 32'h0, 0, 0, 0));
    rst = 1;
    clr_in();
    s_mem = 1;
    step("reset_release_mem", mk(6'b011111, 0, 32'h0, 0, 0, 0));
    clr_in();
    step("reset_idle", mk(6'b0, 0, 32'h0, 0, 0, 0));
  endtask

  task automatic test_priority();
    for (int k = 0; k < 16; k++) begin
      logic [3:0] v;
      v = k[3:0];
      clr_in();
      {s_mem, s_ex, s_id, s_if} = v;
      step("priority", mk(prio(v[3], v[2], v[1], v[0]), 0, 32'h0, 0, 0, 0));
      clr_in();
      step("priority_gap", mk(6'b0, 0, 32'h0, 0, 0, 0));
    end
  endtask

  task automatic test_multi();
    clr_in(); mc_start = 1; mc_cyc = 6'd3;
    step("mc_T", mk(6'b001111, 0, 32'h0, 0, 0, 0));
    clr_in(); mc_start = 1; mc_cyc = 6'd7;
    step("mc_T1_restart_ignored", mk(6'b001111, 0, 32'h0, 0, 1, 0));
    clr_in(); s_mem = 1;
    step("mc_T2_mem", mk(6'b011111, 0, 32'h0, 0, 1, 0));
    clr_in();
    step("mc_T3", mk(6'b001111, 0, 32'h0, 0, 1, 0));
    step("mc_T4_done", mk(6'b0, 0, 32'h0, 1, 0, 0));
    step("mc_T5", mk(6'b0, 0, 32'h0, 0, 0, 0));
    mc_start = 1; mc_cyc = 6'd0;
    step("mc_zero_start", mk(6'b0, 0, 32'h0, 0, 0, 0));
    clr_in();
    repeat (3) step("mc_zero_after", mk(6'b0, 0, 32'h0, 0, 0, 0));
  endtask

  task automatic test_abort();
    clr_in(); mc_start = 1; mc_cyc = 6'd5;
    step("abort_T", mk(6'b001111, 0, 32'h0, 0, 0, 0));
    clr_in();
    step("abort_T1", mk(6'b001111, 0, 32'h0, 0, 1, 0));
    excp = 1; epc = 32'h0000_0180;
    step("abort_T2_excp", mk(6'b001111, 0, 32'h0, 0, 1, 0));
    clr_in(); s_id = 1; s_ex = 1;
    step("abort_T3_flush", mk(6'b0, 1, 32'h0000_0180, 0, 0, 0));
    clr_in();
    repeat (6) step("abort_no_done", mk(6'b0, 0, 32'h0, 0, 0, 0));
  endtask

  task automatic test_back_to_back();
    clr_in(); excp = 1; epc = 32'h0000_0100;
    step("b2b_T", mk(6'b0, 0, 32'h0, 0, 0, 0));
    epc = 32'h0000_0200;
    step("b2b_T1", mk(6'b0, 1, 32'h0000_0100, 0, 0, 0));
    clr_in();
    step("b2b_T2", mk(6'b0, 1, 32'h0000_0200, 0, 0, 0));
    step("b2b_T3", mk(6'b0, 0, 32'h0, 0, 0, 0));
  endtask

  task automatic test_done_excp();
    clr_in(); mc_start = 1; mc_cyc = 6'd1;
    step("dx_T", mk(6'b001111, 0, 32'h0, 0, 0, 0));
    clr_in();
    step("dx_T1", mk(6'b001111, 0, 32'h0, 0, 1, 0));
    excp = 1; epc = 32'h0000_0300; s_mem = 1;
    step("dx_T2_done_excp", mk(6'b011111, 0, 32'h0, 1, 0, 0));
    clr_in();
    step("dx_T3_flush", mk(6'b0, 1, 32'h0000_0300, 0, 0, 0));
    step("dx_T4", mk(6'b0, 0, 32'h0, 0, 0, 0));
  endtask

  task automatic test_wdt();
    clr_in(); s_mem = 1;
    repeat (7) step("wdt_7", mk(6'b011111, 0, 32'h0, 0, 0, 0));
    clr_in();
    step("wdt_gap", mk(6'b0, 0, 32'h0, 0, 0, 0));
    s_mem = 1;
    repeat (8) step("wdt_8", mk(6'b011111, 0, 32'h0, 0, 0, 0));
    clr_in();
    repeat (3) step("wdt_sticky", mk(6'b0, 0, 32'h0, 0, 0, WD));
    s_ex = 1;
    step("wdt_no_effect", mk(6'b001111, 0, 32'h0, 0, 0, WD));
    clr_in();
    rst = 0;
    step("wdt_reset", mk(6'b0, 0, 32'h0, 0, 0, 0));
    rst = 1;
    step("wdt_cleared", mk(6'b0, 0, 32'h0, 0, 0, 0));
  endtask

  initial begin
    rst = 0;
    clr_in();
    @(negedge clk);
    test_reset();
    test_priority();
    test_multi();
    test_abort();
    test_back_to_back();
    test_done_excp();
    test_wdt();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
